// File: rtl/frac_pkg.sv
// Shared definitions for the frac_reduce fraction-reduction block:
// the controller state encoding and the default operand width.
package frac_pkg;

    localparam int FRAC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } frac_state_e;

endpackage

// File: rtl/frac_div.sv
// Single restoring divider: one quotient bit per cycle, MSB first, WIDTH steps.
// done rises with the final step and stays high until the next start.
module frac_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        // Partial remainder stays below divisor, so bit WIDTH of diff is the borrow.
        diff   = rem_sh - {1'b0, dvs_q};
        if (start) begin
            dvd_d  = dividend;
            dvs_d  = divisor;
            quo_d  = '0;
            rem_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            dvd_d = dvd_q << 1;
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/frac_reduce.sv
// Reduces a/b by an upstream gcd g using two parallel restoring dividers.
// Optional lcm output (qa*b) is enabled by defining FRAC_REDUCE_LCM_EN.
module frac_reduce
    import frac_pkg::*;
#(
    parameter int WIDTH = FRAC_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    // Handshakes: a transfer occurs on a rising edge where valid && ready;
    // valid-side data is held stable by its source until that edge.
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   g,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   qa,
    output logic [WIDTH-1:0]   qb,
    output logic               err,
`ifdef FRAC_REDUCE_LCM_EN
    output logic [2*WIDTH-1:0] lcm,
`endif
    output logic [1:0]         dbg_state
);

    frac_state_e      state_q, state_d;
    logic [WIDTH-1:0] qa_q, qa_d, qb_q, qb_d;
    logic             err_q, err_d;
    logic             start;
    logic             rem_bad;
    logic             done_a, done_b;
    logic [WIDTH-1:0] quo_a, quo_b, rem_a, rem_b;
`ifdef FRAC_REDUCE_LCM_EN
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] lcm_q, lcm_d;
`endif

    assign start   = in_valid && (state_q == IDLE) && (g != '0);
    assign rem_bad = (rem_a != '0) || (rem_b != '0);

    always_comb begin
        state_d = state_q;
        qa_d    = qa_q;
        qb_d    = qb_q;
        err_d   = err_q;
`ifdef FRAC_REDUCE_LCM_EN
        b_d     = b_q;
        lcm_d   = lcm_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef FRAC_REDUCE_LCM_EN
                    b_d = b;
`endif
                    if (g == '0) begin
                        state_d = DONE;
                        qa_d    = '0;
                        qb_d    = '0;
                        err_d   = 1'b1;
`ifdef FRAC_REDUCE_LCM_EN
                        lcm_d   = '0;
`endif
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (done_a && done_b) begin
                    state_d = DONE;
                    qa_d    = quo_a;
                    qb_d    = quo_b;
                    err_d   = rem_bad;
`ifdef FRAC_REDUCE_LCM_EN
                    lcm_d   = rem_bad ? '0
                                      : {{WIDTH{1'b0}}, quo_a} * {{WIDTH{1'b0}}, b_q};
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qa_q    <= '0;
            qb_q    <= '0;
            err_q   <= 1'b0;
`ifdef FRAC_REDUCE_LCM_EN
            b_q     <= '0;
            lcm_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
            err_q   <= err_d;
`ifdef FRAC_REDUCE_LCM_EN
            b_q     <= b_d;
            lcm_q   <= lcm_d;
`endif
        end
    end

    frac_div #(.WIDTH(WIDTH)) u_div_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (a),
        .divisor   (g),
        .quotient  (quo_a),
        .remainder (rem_a),
        .done      (done_a)
    );

    frac_div #(.WIDTH(WIDTH)) u_div_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (b),
        .divisor   (g),
        .quotient  (quo_b),
        .remainder (rem_b),
        .done      (done_b)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign qa        = qa_q;
    assign qb        = qb_q;
    assign err       = err_q;
    assign dbg_state = state_q;
`ifdef FRAC_REDUCE_LCM_EN
    assign lcm       = lcm_q;
`endif

endmodule
